block_output: RTL and testbench

BLOCK_OUTPUT -- requirements
Module: block_output

---
 rtl/block_output.sv | 113 +++++++++++
 tb/tb_block_output.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/block_output.sv
// block_output -- output stage of a router port.
//
// Buffers flits from the switch in a small first-word-fall-through FIFO and
// hands them to the neighbour router with a val/ret handshake. A write-side
// packet FSM raises lock between an accepted header and an accepted tail, so
// the switch keeps its grant on this port for the whole packet.
//
// Ports:
//   clk      : single clock, rising edge
//   rst      : asynchronous active-high reset
//   write    : flit strobe from the switch
//   Data_in  : flit from the switch; top two bits are the flit type
//              (10 header, 00 body, 01 tail, 11 single)
//   full     : FIFO full; switch does not send while high
//   lock     : packet in progress
//   drop     : one-cycle pulse after a write refused because the FIFO was full
//   val      : valid flit on Data_out for the neighbour
//   ret      : neighbour can accept a flit this cycle
//   Data_out : flit to the neighbour; zero while val is low
module block_output #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] Data_in,
    output logic                  full,
    output logic                  lock,
    output logic                  drop,
    output logic                  val,
    input  logic                  ret,
    output logic [DATA_WIDTH-1:0] Data_out
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic {
        IDLE,
        IN_PACKET
    } state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  accept;
    logic                  transfer;
    logic [1:0]            flit_type;
    state_t                state;
    state_t                next_state;

    // full comes straight from the registered count, so the accept decision
    // always uses the pre-edge occupancy.
    assign full      = (count == CNT_FULL);
    assign val       = (count != '0);
    assign accept    = write && !full;
    assign transfer  = val && ret;
    assign flit_type = Data_in[DATA_WIDTH-1 -: 2];
    assign Data_out  = val ? mem[rd_ptr] : '0;
    assign lock      = (state == IN_PACKET);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            drop <= write && full;
            if (accept) begin
                mem[wr_ptr] <= Data_in;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (transfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({accept, transfer})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Only accepted flits move the FSM; a header inside a packet or a tail
    // outside one is stored but leaves the state alone.
    always_comb begin
        next_state = state;
        if (accept) begin
            case (state)
                IDLE:      if (flit_type == 2'b10) next_state = IN_PACKET;
                IN_PACKET: if (flit_type == 2'b01) next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_output.sv
module tb_block_output;

    logic       clk;
    logic       rst;
    logic       wr;
    logic [7:0] din;
    logic       full;
    logic       lock;
    logic       drop;
    logic       val;
    logic       ret;
    logic [7:0] dout;

    int unsigned checks;
    int unsigned errors;

    // Reference model: plain queue of accepted flits plus packet flag.
    logic [7:0] mq[$];
    bit         m_lock;
    bit         m_drop;

    typedef struct packed {
        logic       w;
        logic [7:0] d;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        logic       ef;
        logic       el;
        logic       edr;
    } vec_t;

    vec_t vecs [17];

    block_output #(
        .DATA_WIDTH(8),
        .DEPTH_LOG2(2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .write    (wr),
        .Data_in  (din),
        .full     (full),
        .lock     (lock),
        .drop     (drop),
        .val      (val),
        .ret      (ret),
        .Data_out (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic w, input logic [7:0] d, input logic r);
        bit pf;
        bit pv;
        pf = (mq.size() == 4);
        pv = (mq.size() != 0);
        m_drop = w && pf;
        if (pv && r) void'(mq.pop_front());
        if (w && !pf) begin
            mq.push_back(d);
            if (d[7:6] == 2'b10) m_lock = 1'b1;
            else if (d[7:6] == 2'b01) m_lock = 1'b0;
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] ed;
        ed = (mq.size() != 0) ? mq[0] : 8'h00;
        chk({tag, ".val"},  32'(val),  32'(mq.size() != 0));
        chk({tag, ".data"}, 32'(dout), 32'(ed));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == 4));
        chk({tag, ".lock"}, 32'(lock), 32'(m_lock));
        chk({tag, ".drop"}, 32'(drop), 32'(m_drop));
    endtask

    task automatic step(input string tag, input logic w, input logic [7:0] d, input logic r);
        wr  = w;
        din = d;
        ret = r;
        model_step(w, d, r);
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr  = 1'b0;
        din = 8'h00;
        ret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.val",  32'(val),  32'd0);
        chk("rst.data", 32'(dout), 32'd0);
        chk("rst.full", 32'(full), 32'd0);
        chk("rst.lock", 32'(lock), 32'd0);
        chk("rst.drop", 32'(drop), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_lock = 1'b0;
        m_drop = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Fill/stall with refused fifth write, then drain.
        vecs[0]  = '{1'b1, 8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        // FSM corner: tail in IDLE, header, header inside packet, tail.
        vecs[9]  = '{1'b1, 8'h7E, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 8'h80, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h90, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h41, 1'b0, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h90, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};

        do_reset();

        for (int i = 0; i < 17; i++) begin
            wr  = vecs[i].w;
            din = vecs[i].d;
            ret = vecs[i].r;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d.val", i),  32'(val),  32'(vecs[i].ev));
            chk($sformatf("vec%0d.data", i), 32'(dout), 32'(vecs[i].ed));
            chk($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].ef));
            chk($sformatf("vec%0d.lock", i), 32'(lock), 32'(vecs[i].el));
            chk($sformatf("vec%0d.drop", i), 32'(drop), 32'(vecs[i].edr));
        end

        // Single flit, one-cycle latency, then empty again.
        do_reset();
        step("single.wr", 1'b1, 8'hC5, 1'b1);
        chk("single.c5", 32'(dout), 32'hC5);
        step("single.out", 1'b0, 8'h00, 1'b1);
        chk("single.empty", 32'(val), 32'd0);

        // Handshake stall with three flits queued.
        do_reset();
        step("stall.q0", 1'b1, 8'h81, 1'b0);
        step("stall.q1", 1'b1, 8'h02, 1'b0);
        step("stall.q2", 1'b1, 8'h43, 1'b0);
        step("stall.r1", 1'b0, 8'h00, 1'b1);
        step("stall.r0a", 1'b0, 8'h00, 1'b0);
        step("stall.r0b", 1'b0, 8'h00, 1'b0);
        step("stall.r1b", 1'b0, 8'h00, 1'b1);
        step("stall.d0", 1'b0, 8'h00, 1'b1);
        step("stall.d1", 1'b0, 8'h00, 1'b1);

        // Continuous streaming: 12 flits, pointers wrap three times.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] f;
            f = 8'(i);
            if (i == 0) f = f | 8'h80;
            else if (i == 11) f = f | 8'h40;
            step($sformatf("stream%0d", i), 1'b1, f, 1'b1);
        end
        step("stream.drain0", 1'b0, 8'h00, 1'b1);
        step("stream.drain1", 1'b0, 8'h00, 1'b1);

        // Asynchronous reset mid-packet, between clock edges.
        do_reset();
        step("ar.q0", 1'b1, 8'h81, 1'b0);
        step("ar.q1", 1'b1, 8'h02, 1'b0);
        step("ar.q2", 1'b1, 8'h03, 1'b0);
        wr = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("ar.val",  32'(val),  32'd0);
        chk("ar.full", 32'(full), 32'd0);
        chk("ar.lock", 32'(lock), 32'd0);
        chk("ar.data", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        m_lock = 1'b0;
        m_drop = 1'b0;
        for (int i = 0; i < 4; i++) step($sformatf("ar.idle%0d", i), 1'b0, 8'h00, 1'b1);
        step("ar.first", 1'b1, 8'hC3, 1'b1);
        step("ar.after", 1'b0, 8'h00, 1'b1);

        // Randomised traffic against the queue model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic       w;
            logic       r;
            logic [7:0] d;
            w = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 9) < 6);
            d = 8'($urandom);
            step($sformatf("rand%0d", i), w, d, r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
